srs_ang2iq: RTL and testbench

SRS_ANG2IQ -- requirements
Module: srs_ang2iq

---
 rtl/srs_ang2iq.sv | 133 +++++++++++++
 tb/tb_srs_ang2iq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srs_ang2iq.sv
// srs_ang2iq: converts a phase (R12S10, units of pi) into cos/sin IQ samples
// using a quarter-wave ROM; a small sequencer frames one symbol of m_sc samples.
module srs_ang2iq #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] m_sc,
  input  logic        phi_en,
  input  logic [11:0] phi_val,
  output logic        busy,
  output logic        done,
  output logic        iq_en,
  output logic [15:0] i_val,
  output logic [15:0] q_val
);
  // state | meaning
  // IDLE  | waiting for start; phi_en ignored
  // RUN   | accepting phi_en until m_sc samples have been taken
  // FLUSH | draining the pipeline, then one done cycle before IDLE
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam real PI = 3.14159265358979323846;

  state_t         state;
  logic [10:0]    m_sc_q;
  logic [10:0]    in_cnt;
  logic [10:0]    out_cnt;
  logic [LAT-1:0] vld;
  logic           accept;
  logic [1:0]     qd1;
  logic [1:0]     qd2;
  logic [9:0]     k1;
  logic [9:0]     kc1;
  logic [13:0]    rom_k;
  logic [13:0]    rom_kc;
  logic [13:0]    rom [0:512];
  logic           unused_phi_sign;

  assign accept          = (state == RUN) && phi_en;
  assign iq_en           = vld[LAT-1];
  assign unused_phi_sign = phi_val[11];

  // Quarter-wave table L(j) = round(16383*sin(j*pi/1024)), folded to constants.
  for (genvar j = 0; j <= 512; j++) begin : g_rom
    localparam logic [13:0] LV = 14'($rtoi(16383.0 * $sin(real'(j) * PI / 1024.0) + 0.5));
    assign rom[j] = LV;
  end

  function automatic logic [15:0] pos(input logic [13:0] x);
    return {2'b00, x};
  endfunction

  function automatic logic [15:0] neg(input logic [13:0] x);
    return -{2'b00, x};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      qd1    <= '0;
      k1     <= '0;
      kc1    <= '0;
      qd2    <= '0;
      rom_k  <= '0;
      rom_kc <= '0;
      i_val  <= '0;
      q_val  <= '0;
    end else begin
      vld <= {vld[LAT-2:0], accept};
      if (accept) begin
        qd1 <= phi_val[10:9];
        k1  <= {1'b0, phi_val[8:0]};
        kc1 <= 10'd512 - {1'b0, phi_val[8:0]};
      end
      if (vld[0]) begin
        qd2    <= qd1;
        rom_k  <= rom[k1];
        rom_kc <= rom[kc1];
      end
      if (vld[1]) begin
        case (qd2)
          2'd0: begin i_val <= pos(rom_kc); q_val <= pos(rom_k);  end
          2'd1: begin i_val <= neg(rom_k);  q_val <= pos(rom_kc); end
          2'd2: begin i_val <= neg(rom_kc); q_val <= neg(rom_k);  end
          default: begin i_val <= pos(rom_k); q_val <= neg(rom_kc); end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_sc_q  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (vld[LAT-2]) out_cnt <= out_cnt + 11'd1;
      case (state)
        IDLE: begin
          if (start) begin
            m_sc_q  <= m_sc;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            state   <= (m_sc == 11'd0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (phi_en) begin
            in_cnt <= in_cnt + 11'd1;
            if (in_cnt + 11'd1 == m_sc_q) state <= FLUSH;
          end
        end
        default: begin
          // done is held for one cycle while still busy, then drop to IDLE
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (out_cnt == m_sc_q) begin
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srs_ang2iq.sv
// Self-checking bench for srs_ang2iq: randomized and directed symbols compared
// against a cos/sin reference model and a symbol-level timing model.
module tb_srs_ang2iq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] m_sc;
  logic        phi_en;
  logic [11:0] phi_val;
  logic        busy;
  logic        done;
  logic        iq_en;
  logic [15:0] i_val;
  logic [15:0] q_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam int NEVER = 32'h7fffffff;

  // observed outputs per cycle
  logic        obs_en   [int];
  logic        obs_done [int];
  logic        obs_busy [int];
  logic [15:0] obs_i    [int];
  logic [15:0] obs_q    [int];

  // model expectations per cycle
  logic [31:0] exp_iq   [int];
  bit          exp_done [int];
  int          m_busy_to  = -1;
  int          m_run_from = NEVER;
  int          m_left     = 0;

  srs_ang2iq #(.LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .m_sc(m_sc), .phi_en(phi_en),
    .phi_val(phi_val), .busy(busy), .done(done), .iq_en(iq_en),
    .i_val(i_val), .q_val(q_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_en[cyc]   = iq_en;
    obs_done[cyc] = done;
    obs_busy[cyc] = busy;
    obs_i[cyc]    = i_val;
    obs_q[cyc]    = q_val;
  end

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Reference: angle = pi * (phase mod 2) taken directly from the 11 LSBs
  function automatic logic [31:0] ref_iq(input logic [11:0] pv);
    real ang;
    logic [15:0] ri, rq;
    ang = 3.14159265358979323846 * real'(pv[10:0]) / 1024.0;
    ri = 16'(rnd(16383.0 * $cos(ang)));
    rq = 16'(rnd(16383.0 * $sin(ang)));
    return {ri, rq};
  endfunction

  // Drive one cycle of inputs (called at a negedge) and advance the model.
  task automatic drive(input logic st, input logic [10:0] ms, input logic pe,
                       input logic [11:0] pv);
    int p;
    p = cyc;
    start = st; m_sc = ms; phi_en = pe; phi_val = pv;
    if (pe && m_left > 0 && p >= m_run_from) begin
      exp_iq[p + 3] = ref_iq(pv);
      m_left--;
      if (m_left == 0) begin
        m_busy_to = p + 4;
        exp_done[p + 4] = 1'b1;
        m_run_from = NEVER;
      end
    end
    if (st && p > m_busy_to) begin
      m_left = int'(ms);
      if (ms == 11'd0) begin
        m_busy_to = p + 2;
        exp_done[p + 2] = 1'b1;
        m_run_from = NEVER;
      end else begin
        m_busy_to = NEVER;
        m_run_from = p + 1;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, away from any clock edge; returns with reset still high.
  task automatic do_reset();
    int kq[$];
    #2 rst = 1'b1;
    start = 1'b0; phi_en = 1'b0;
    foreach (exp_iq[k]) if (k > cyc) kq.push_back(k);
    foreach (kq[j]) exp_iq.delete(kq[j]);
    kq.delete();
    foreach (exp_done[k]) if (k > cyc) kq.push_back(k);
    foreach (kq[j]) exp_done.delete(kq[j]);
    m_busy_to = -1; m_run_from = NEVER; m_left = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || iq_en !== 1'b0 || i_val !== 16'h0 || q_val !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b iq_en=%b i=%h q=%h, want all 0",
               busy, done, iq_en, i_val, q_val);
    end
    release_reset();
  endtask

  task automatic test_quadrants();
    int t0, p;
    int ci[4] = '{16383, 11585, 0, -11585};
    int cq[4] = '{0, 11585, 16383, 11585};
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    p = cyc;
    drive(1'b1, 11'd4, 1'b0, 12'd0);
    drive(1'b0, 11'd0, 1'b1, 12'd0);
    drive(1'b0, 11'd0, 1'b1, 12'd256);
    drive(1'b0, 11'd0, 1'b1, 12'd512);
    drive(1'b0, 11'd0, 1'b1, 12'd768);
    repeat (7) drive(1'b0, 11'd0, 1'b0, 12'd0);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_en[p + 4 + j] !== 1'b1 || $signed(obs_i[p + 4 + j]) !== ci[j] || $signed(obs_q[p + 4 + j]) !== cq[j]) begin
        errors++;
        $display("FAIL quad_const[%0d]: got en=%b i=%0d q=%0d, want en=1 i=%0d q=%0d",
                 j, obs_en[p + 4 + j], $signed(obs_i[p + 4 + j]), $signed(obs_q[p + 4 + j]), ci[j], cq[j]);
      end
    end
    checks++;
    if (obs_done[p + 8] !== 1'b1) begin
      errors++;
      $display("FAIL quad_done: got done=%b at last iq_en+1, want 1", obs_done[p + 8]);
    end
    checks++;
    if (iq_en !== 1'b0 || $signed(i_val) !== -16'sd11585 || $signed(q_val) !== 16'sd11585) begin
      errors++;
      $display("FAIL quad_hold: got en=%b i=%0d q=%0d, want en=0 i=-11585 q=11585",
               iq_en, $signed(i_val), $signed(q_val));
    end
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL quad_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
    end
  endtask

  task automatic test_wrap();
    int t0, p;
    logic [11:0] pv[3] = '{12'hC00, 12'h400, 12'hE00};
    int ci[3] = '{-16383, -16383, 0};
    int cq[3] = '{0, 0, -16383};
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    p = cyc;
    drive(1'b1, 11'd3, 1'b0, 12'd0);
    for (int j = 0; j < 3; j++) drive(1'b0, 11'd0, 1'b1, pv[j]);
    repeat (6) drive(1'b0, 11'd0, 1'b0, 12'd0);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (obs_en[p + 4 + j] !== 1'b1 || $signed(obs_i[p + 4 + j]) !== ci[j] || $signed(obs_q[p + 4 + j]) !== cq[j]) begin
        errors++;
        $display("FAIL wrap_const[%0d]: got en=%b i=%0d q=%0d, want en=1 i=%0d q=%0d",
                 j, obs_en[p + 4 + j], $signed(obs_i[p + 4 + j]), $signed(obs_q[p + 4 + j]), ci[j], cq[j]);
      end
    end
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL wrap_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
    end
  endtask

  task automatic test_zero_len();
    int t0, p;
    logic xe, xd, xb;
    t0 = cyc;
    p = cyc;
    drive(1'b1, 11'd0, 1'b0, 12'd0);
    drive(1'b0, 11'd0, 1'b1, 12'd100);
    drive(1'b1, 11'd0, 1'b1, 12'd200);  // start coincident with the return to IDLE
    repeat (5) drive(1'b0, 11'd0, 1'b0, 12'd0);
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      xb = (c == p + 1) || (c == p + 2);
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || obs_busy[c] !== xb) begin
        errors++;
        $display("FAIL zero_len cyc=%0d: got en=%b done=%b busy=%b, want en=%b done=%b busy=%b",
                 c, obs_en[c], obs_done[c], obs_busy[c], xe, xd, xb);
      end
    end
  endtask

  task automatic test_overrun();
    int t0, n_iq;
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    n_iq = 0;
    repeat (3) drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    drive(1'b1, 11'd3, 1'b0, 12'd0);
    for (int j = 0; j < 5; j++) drive(j == 1, 11'd7, 1'b1, 12'($urandom));
    repeat (7) drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    for (int c = t0; c < cyc; c++) begin
      if (obs_en[c] === 1'b1) n_iq++;
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL overrun_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
    end
    checks++;
    if (n_iq != 3) begin
      errors++;
      $display("FAIL overrun_count: got %0d iq_en, want 3", n_iq);
    end
  endtask

  task automatic test_rst_mid_run();
    int t0;
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    drive(1'b1, 11'd8, 1'b0, 12'd0);
    drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || iq_en !== 1'b0 || i_val !== 16'h0 || q_val !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b done=%b iq_en=%b i=%h q=%h, want all 0",
               busy, done, iq_en, i_val, q_val);
    end
    release_reset();
    repeat (8) drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    drive(1'b1, 11'd8, 1'b0, 12'd0);
    for (int n = 0; n < 30; n++) drive(1'b0, 11'd0, (n % 3) != 2, 12'($urandom));
    repeat (6) drive(1'b0, 11'd0, 1'b0, 12'd0);
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL rst_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
    end
  endtask

  task automatic test_sweep();
    int t0, mag;
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    for (int h = 0; h < 2; h++) begin
      drive(1'b1, 11'd1024, 1'b0, 12'd0);
      for (int v = 0; v < 1024; v++) drive(1'b0, 11'd0, 1'b1, 12'(h * 1024 + v));
      repeat (6) drive(1'b0, 11'd0, 1'b0, 12'd0);
    end
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL sweep_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
      if (obs_en[c] === 1'b1) begin
        mag = int'($signed(obs_i[c])) * int'($signed(obs_i[c])) + int'($signed(obs_q[c])) * int'($signed(obs_q[c]));
        checks++;
        if (mag < 16383 * 16383 - 65536 || mag > 16383 * 16383 + 65536) begin
          errors++;
          $display("FAIL sweep_mag cyc=%0d: got i^2+q^2=%0d, want within 65536 of %0d",
                   c, mag, 16383 * 16383);
        end
      end
    end
  endtask

  task automatic test_random();
    int t0;
    logic xe, xd;
    logic [31:0] ev;
    t0 = cyc;
    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 15) == 0, 11'($urandom_range(0, 12)),
            $urandom_range(0, 3) != 0, 12'($urandom));
    repeat (40) drive(1'b0, 11'd0, 1'b1, 12'($urandom));
    repeat (8) drive(1'b0, 11'd0, 1'b0, 12'd0);
    for (int c = t0; c < cyc; c++) begin
      xe = exp_iq.exists(c); xd = exp_done.exists(c);
      ev = xe ? exp_iq[c] : 32'h0;
      checks++;
      if (obs_en[c] !== xe || obs_done[c] !== xd || (xe && {obs_i[c], obs_q[c]} !== ev)) begin
        errors++;
        $display("FAIL random_stream cyc=%0d: got en=%b done=%b i=%0d q=%0d, want en=%b done=%b i=%0d q=%0d",
                 c, obs_en[c], obs_done[c], $signed(obs_i[c]), $signed(obs_q[c]),
                 xe, xd, $signed(ev[31:16]), $signed(ev[15:0]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    m_sc = '0;
    phi_en = 1'b0;
    phi_val = '0;
    test_reset();
    test_quadrants();
    test_wrap();
    test_zero_len();
    test_overrun();
    test_rst_mid_run();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
